// File: rtl/demux_1_to_6_sched_if.sv
// demux_1_to_6_sched_if: word-stream and demux-side signal bundle for the
// 1-to-6 demux sequencer. The slave modport is the sequencer's view; the
// master modport is the view of whatever drives the sequencer.
// Optional macro DEMUX_SCHED_LANE_MASK_EN adds the per-frame lane_mask input.
`timescale 1ns/1ps
interface demux_1_to_6_sched_if #(
   parameter int DATA_W    = 5,
   parameter int NUM_LANES = 6,
   parameter int SEL_W     = 3
);
   logic                 start;
   logic [DATA_W-1:0]    in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_W-1:0]    dm_din;
   logic [SEL_W-1:0]     dm_sel;
   logic [NUM_LANES-1:0] lane_valid;
   logic [NUM_LANES-1:0] lane_ready;
   logic                 busy;
   logic                 done;
`ifdef DEMUX_SCHED_LANE_MASK_EN
   logic [NUM_LANES-1:0] lane_mask;
`endif

   modport slave (
      input  start, in_data, in_valid, lane_ready,
`ifdef DEMUX_SCHED_LANE_MASK_EN
      input  lane_mask,
`endif
      output in_ready, dm_din, dm_sel, lane_valid, busy, done
   );

   modport master (
      output start, in_data, in_valid, lane_ready,
`ifdef DEMUX_SCHED_LANE_MASK_EN
      output lane_mask,
`endif
      input  in_ready, dm_din, dm_sel, lane_valid, busy, done
   );
endinterface

// File: rtl/demux_1_to_6_sched.sv
// demux_1_to_6_sched: sequences a valid/ready word stream onto the 1-to-6
// demux. Each frame delivers BURST_LEN words to each served lane in ascending
// lane order through a single registered output stage (dm_din/dm_sel/lane_valid).
// Optional macro DEMUX_SCHED_LANE_MASK_EN: lane_mask sampled at start skips lanes;
// an all-masked frame goes straight from IDLE to DONE without taking input.
`timescale 1ns/1ps
module demux_1_to_6_sched #(
   parameter int DATA_W    = 5,
   parameter int NUM_LANES = 6,
   parameter int BURST_LEN = 9,
   parameter int SEL_W     = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   demux_1_to_6_sched_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

   state_t               state_r;
   logic [SEL_W-1:0]     lane_r;
   logic [7:0]           cnt_r;
   logic                 final_r;
   logic [DATA_W-1:0]    din_r;
   logic [SEL_W-1:0]     sel_r;
   logic [NUM_LANES-1:0] lv_r;
   logic                 busy_r;
   logic                 done_r;

   logic [NUM_LANES-1:0] start_mask_s;
   logic [NUM_LANES-1:0] run_mask_s;
   logic [SEL_W:0]       first_s;
   logic [SEL_W:0]       next_s;
   logic                 in_ready_s;
   logic                 accept_s;
   logic                 xfer_s;

`ifdef DEMUX_SCHED_LANE_MASK_EN
   logic [NUM_LANES-1:0] mask_r;
   assign start_mask_s = bus.lane_mask;
   assign run_mask_s   = mask_r;
`else
   assign start_mask_s = {NUM_LANES{1'b0}};
   assign run_mask_s   = {NUM_LANES{1'b0}};
`endif

   // Lowest unmasked lane strictly above cur; MSB of the result flags "found".
   function automatic logic [SEL_W:0] next_lane(input logic [NUM_LANES-1:0] mask,
                                                 input int cur);
      logic [SEL_W:0] res;
      res = {(SEL_W+1){1'b0}};
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         if ((k > cur) && !mask[k]) begin
            res = {1'b1, SEL_W'(k)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Handshake decode: in_ready follows lane_ready of the held word combinationally.
   always_comb begin
      xfer_s     = 1'b0;
      in_ready_s = 1'b0;
      accept_s   = 1'b0;
      first_s    = {(SEL_W+1){1'b0}};
      next_s     = {(SEL_W+1){1'b0}};
      xfer_s     = (lv_r != {NUM_LANES{1'b0}}) && bus.lane_ready[sel_r];
      in_ready_s = (state_r == ST_RUN) && !final_r &&
                   ((lv_r == {NUM_LANES{1'b0}}) || bus.lane_ready[sel_r]);
      accept_s   = bus.in_valid && in_ready_s;
      first_s    = next_lane(start_mask_s, -32'sd1);
      next_s     = next_lane(run_mask_s, int'(lane_r));
   end

   // Frame FSM together with the registered demux output stage and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         lane_r  <= {SEL_W{1'b0}};
         cnt_r   <= 8'd0;
         final_r <= 1'b0;
         din_r   <= {DATA_W{1'b0}};
         sel_r   <= {SEL_W{1'b0}};
         lv_r    <= {NUM_LANES{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
`ifdef DEMUX_SCHED_LANE_MASK_EN
         mask_r  <= {NUM_LANES{1'b0}};
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  busy_r  <= 1'b1;
                  cnt_r   <= 8'd0;
                  final_r <= 1'b0;
`ifdef DEMUX_SCHED_LANE_MASK_EN
                  mask_r  <= bus.lane_mask;
`endif
                  if (first_s[SEL_W]) begin
                     state_r <= ST_RUN;
                     lane_r  <= first_s[SEL_W-1:0];
                  end else begin
                     // Nothing to serve: skip RUN entirely.
                     state_r <= ST_DONE;
                     lane_r  <= {SEL_W{1'b0}};
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end

            ST_RUN: begin
               if (accept_s) begin
                  din_r <= bus.in_data;
                  sel_r <= lane_r;
                  lv_r  <= {{(NUM_LANES-1){1'b0}}, 1'b1} << lane_r;
                  if (cnt_r == LAST_CNT) begin
                     cnt_r <= 8'd0;
                     if (next_s[SEL_W]) begin
                        lane_r <= next_s[SEL_W-1:0];
                     end else begin
                        // Last word of the last served lane: stop accepting.
                        final_r <= 1'b1;
                     end
                  end else begin
                     cnt_r <= cnt_r + 8'd1;
                  end
               end else if (xfer_s) begin
                  lv_r <= {NUM_LANES{1'b0}};
                  if (final_r) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end else begin
                  // Held word waits for its lane.
                  state_r <= ST_RUN;
               end
            end

            ST_DONE: begin
               if (done_r) begin
                  done_r  <= 1'b0;
                  state_r <= ST_IDLE;
                  final_r <= 1'b0;
                  lane_r  <= {SEL_W{1'b0}};
               end else begin
                  // Entered directly from IDLE: spend one busy cycle, then pulse done.
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
               end
            end

            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.dm_din     = din_r;
   assign bus.dm_sel     = sel_r;
   assign bus.lane_valid = lv_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;

endmodule
